// File: rtl/alu_issue_ctrl.sv
// Single-outstanding issue sequencer between decode and the 32-bit ALU.
// Holds ALU operands for the op's class latency, then returns a tagged result.
module alu_issue_ctrl #(
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [4:0]       in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_ctrl,
  input  logic [31:0]      alu_y,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int MAX_AM  = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic [CNT_W-1:0] lat_sel;
  logic             err_sel;
  logic             accept;

  // Class decode: illegal codes run at ALU latency and are flagged.
  always_comb begin
    lat_sel = CNT_W'(ALU_LAT);
    err_sel = 1'b0;
    case (in_ctrl)
      5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd16, 5'd21: ;
      5'd8, 5'd9, 5'd10, 5'd11:    lat_sel = CNT_W'(MUL_LAT);
      5'd12, 5'd13, 5'd14, 5'd15:  lat_sel = CNT_W'(DIV_LAT);
      default:                     err_sel = 1'b1;
    endcase
  end

  // Both handshakes are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; ready may depend combinationally on out_ready.
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cout  <= 1'b0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else begin
      // Operands change only here so the shifter and mult/div see stable inputs.
      if (accept) begin
        alu_a    <= in_a;
        alu_b    <= in_b;
        alu_ctrl <= in_ctrl;
        tag_q    <= in_tag;
        err_q    <= err_sel;
        cnt      <= lat_sel;
        state    <= EXEC;
      end
      case (state)
        IDLE: ;
        EXEC: begin
          if (cnt == CNT_W'(1)) begin
            out_y     <= err_q ? 32'd0 : alu_y;
            out_cout  <= err_q ? 1'b0 : alu_cout;
            out_tag   <= tag_q;
            out_err   <= err_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!accept) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a stub ALU, directed scenarios and random traffic
// checked against a time-based model of accept/capture/handshake events.
module tb_alu_issue_ctrl;

  localparam int TAG_W   = 4;
  localparam int ALU_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;
  localparam int W       = TAG_W + 34;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [4:0]       in_ctrl = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      alu_a, alu_b;
  logic [4:0]       alu_ctrl;
  logic [31:0]      alu_y;
  logic             alu_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_y;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  alu_issue_ctrl #(
    .TAG_W(TAG_W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cout(out_cout), .out_tag(out_tag), .out_err(out_err),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stub ALU ----------------
  function automatic logic [32:0] alu_model(input logic [4:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] r;
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (c)
      5'd0:  r = {1'b0, a} + {1'b0, b};
      5'd16: r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      5'd1:  r = {1'b0, a << b[4:0]};
      5'd4:  r = {1'b0, a ^ b};
      5'd5:  r = {1'b0, a >> b[4:0]};
      5'd6:  r = {1'b0, a | b};
      5'd7:  r = {1'b0, a & b};
      5'd21: r = {1'b0, 32'($signed(a) >>> b[4:0])};
      5'd8:  begin p = {32'b0, a} * {32'b0, b}; r = {1'b0, p[31:0]}; end
      5'd9:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = {1'b0, p[63:32]}; end
      5'd10: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = {1'b0, p[63:32]}; end
      5'd11: begin p = {32'b0, a} * {32'b0, b}; r = {1'b0, p[63:32]}; end
      5'd12: r = {1'b0, (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b))};
      5'd13: r = {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
      5'd14: r = {1'b0, (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b))};
      5'd15: r = {1'b0, (b == 0) ? a : a % b};
      default: r = {1'b1, a ^ b ^ 32'hDEAD_BEEF};
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_y} = alu_model(alu_ctrl, alu_a, alu_b);

  // ---------------- reference model ----------------
  function automatic int lat_of(input logic [4:0] c);
    if (c >= 5'd8 && c <= 5'd11) return MUL_LAT;
    if (c >= 5'd12 && c <= 5'd15) return DIV_LAT;
    return ALU_LAT;
  endfunction

  function automatic logic err_of(input logic [4:0] c);
    if (c >= 5'd8 && c <= 5'd15) return 1'b0;
    return !(c == 5'd0 || c == 5'd1 || (c >= 5'd4 && c <= 5'd7) || c == 5'd16 || c == 5'd21);
  endfunction

  function automatic logic [W-1:0] expect_result(input logic [4:0] c, input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic [TAG_W-1:0] t);
    if (err_of(c)) return {1'b1, t, 33'd0};
    return {1'b0, t, alu_model(c, a, b)};
  endfunction

  logic [W-1:0] exp_q[$];
  logic         m_active = 1'b0;
  int           m_acc = 0;
  int           m_lat = 0;
  int           edge_n = 0;
  logic [31:0]  m_a = '0, m_b = '0;
  logic [4:0]   m_c = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, check pre-edge view, advance model, take the edge.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] c, input logic [TAG_W-1:0] t, input logic ordy);
    logic         exec, done, exp_rdy;
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; in_ctrl = c; in_tag = t; out_ready = ordy;
    #1;
    exec    = m_active && ((edge_n - m_acc) < m_lat);
    done    = m_active && !exec;
    exp_rdy = !m_active || (done && ordy);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_active));
    check("out_valid", 64'(out_valid), 64'(done));
    check("alu_a", 64'(alu_a), 64'(m_a));
    check("alu_b", 64'(alu_b), 64'(m_b));
    check("alu_ctrl", 64'(alu_ctrl), 64'(m_c));
    if (done) begin
      check("sb_size", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("out_y", 64'(out_y), 64'(e[31:0]));
        check("out_cout", 64'(out_cout), 64'(e[32]));
        check("out_tag", 64'(out_tag), 64'(e[33 +: TAG_W]));
        check("out_err", 64'(out_err), 64'(e[W-1]));
      end
      if (ordy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_active = 1'b0;
      end
    end
    if (exp_rdy && iv) begin
      m_active = 1'b1;
      m_acc    = edge_n + 1;
      m_lat    = lat_of(c);
      m_a = a; m_b = b; m_c = c;
      exp_q.push_back(expect_result(c, a, b, t));
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 5'd0, '0, ordy);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst = 1'b0;
    m_active = 1'b0; m_a = '0; m_b = '0; m_c = '0;
    exp_q.delete();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] c;
    reset_pulse();

    // Add: result two edges after accept.
    step(1'b1, 32'd5, 32'd7, 5'd0, 4'd3, 1'b0);
    idle(2, 1'b0);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_y", 64'(out_y), 64'd12);
    check("add_tag", 64'(out_tag), 64'd3);
    check("add_err", 64'(out_err), 64'd0);

    // Sub held in DONE for five cycles, then released.
    step(1'b1, 32'd5, 32'd7, 5'd16, 4'd5, 1'b1);
    idle(7, 1'b0);
    check("sub_y", 64'(out_y), 64'hFFFF_FFFE);
    check("sub_cout", 64'(out_cout), 64'd0);
    idle(1, 1'b1);
    check("sub_idle", 64'(busy), 64'd0);

    // mul then mulhu back to back.
    step(1'b1, 32'h1_0000, 32'h1_0000, 5'd8, 4'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h1_0000, 32'h1_0000, 5'd11, 4'd2, 1'b1);
      if (i == 2) check("mul_lo", 64'(out_y), 64'd0);
      if (i == 6) check("mulhu", 64'(out_y), 64'd1);
    end
    idle(6, 1'b1);

    // div with a second request held until DONE.
    step(1'b1, 32'd100, 32'd7, 5'd12, 4'd4, 1'b1);
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 32'd1, 32'd2, 5'd0, 4'd9, 1'b1);
      if (i == 32) check("div_busy", 64'(busy), 64'd1);
      if (i == 33) check("div_y", 64'(out_y), 64'd14);
    end
    idle(4, 1'b1);

    // Illegal code: zeroed result with err.
    step(1'b1, 32'd9, 32'd9, 5'd3, 4'd6, 1'b0);
    idle(2, 1'b0);
    check("ill_err", 64'(out_err), 64'd1);
    check("ill_y", 64'(out_y), 64'd0);
    check("ill_cout", 64'(out_cout), 64'd0);
    idle(2, 1'b1);

    // Reset in the middle of a div, then a normal add.
    step(1'b1, 32'd100, 32'd7, 5'd12, 4'd7, 1'b0);
    idle(9, 1'b0);
    reset_pulse();
    step(1'b1, 32'd5, 32'd7, 5'd0, 4'd8, 1'b0);
    idle(1, 1'b0);
    check("post_rst_pending", 64'(out_valid), 64'd0);
    idle(1, 1'b0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_y", 64'(out_y), 64'd12);
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      c = 5'($urandom_range(0, 31));
      if (c >= 5'd12 && c <= 5'd15 && $urandom_range(0, 2) != 0) c = 5'($urandom_range(0, 11));
      if ($urandom_range(0, 249) == 0) reset_pulse();
      step($urandom_range(0, 3) != 0, $urandom, $urandom, c, TAG_W'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0);
    end
    idle(40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
